dbus_mmio_resp: RTL and testbench



---
 rtl/dbus_mmio_resp_pkg.sv | 27 ++
 rtl/sat_counter32.sv | 25 ++
 rtl/dbus_mmio_resp.sv | 110 +++++++++++
 tb/tb_dbus_mmio_resp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_mmio_resp_pkg.sv
// rtl/dbus_mmio_resp_pkg.sv - shared types and register offsets for the CPU data-bus MMIO responder
package dbus_mmio_resp_pkg;

    // Register offsets within the 16-byte MMIO window
    localparam logic [3:0] OFF_CYC  = 4'h0;
    localparam logic [3:0] OFF_STL  = 4'h4;
    localparam logic [3:0] OFF_STAT = 4'h8;
    localparam logic [3:0] OFF_SCR  = 4'hC;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Which register, if any, the current address selects
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_CYC  = 3'd1,
        SEL_STL  = 3'd2,
        SEL_STAT = 3'd3,
        SEL_SCR  = 3'd4,
        SEL_FIN  = 3'd5
    } sel_t;

endpackage

// File: rtl/sat_counter32.sv
// rtl/sat_counter32.sv - 32-bit up counter with enable, synchronous clear and saturation
//
// Ports:
//   clk   - clock, rising edge
//   clr   - synchronous clear, active-high, dominates enable
//   en    - count enable
//   count - current count, holds at all-ones instead of wrapping
module sat_counter32
    import dbus_mmio_resp_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= 32'd0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/dbus_mmio_resp.sv
// rtl/dbus_mmio_resp.sv - MMIO responder for the CPU data bus: finish register, perf counters, status, scratch
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   addr, wdata  - CPU data address and store data
//   we           - CPU store strobe
//   stall_in     - CPU pipeline stall indication
//   rdata, hit   - combinational read data and register-decode hit
//   done, result - program finished flag and the value stored to the finish address
//   cycle_count  - cycles spent running
//   stall_count  - stalled cycles spent running
module dbus_mmio_resp
    import dbus_mmio_resp_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR   = 32'h0000_7FF0,
    parameter logic [DATA_W-1:0] FINISH_ADDR = 32'h0000_7FFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              stall_in,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [31:0]       cycle_count,
    output logic [31:0]       stall_count
);

    state_t            state_q;
    state_t            state_d;
    sel_t              sel;
    logic [DATA_W-1:0] scratch_q;
    logic              run;
    logic              fin_store;
    logic              scr_store;

    // Exact byte-address decode; anything else is left to dmem
    always_comb begin
        sel = SEL_NONE;
        if (addr == BASE_ADDR + DATA_W'(OFF_CYC)) begin
            sel = SEL_CYC;
        end else if (addr == BASE_ADDR + DATA_W'(OFF_STL)) begin
            sel = SEL_STL;
        end else if (addr == BASE_ADDR + DATA_W'(OFF_STAT)) begin
            sel = SEL_STAT;
        end else if (addr == BASE_ADDR + DATA_W'(OFF_SCR)) begin
            sel = SEL_SCR;
        end else if (addr == FINISH_ADDR) begin
            sel = SEL_FIN;
        end
    end

    assign run       = (state_q == ST_RUN);
    assign fin_store = run && we && (sel == SEL_FIN);
    assign scr_store = run && we && (sel == SEL_SCR);
    assign done      = (state_q == ST_DONE);
    assign hit       = (sel != SEL_NONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (fin_store) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            result    <= '0;
            scratch_q <= '0;
        end else begin
            state_q <= state_d;
            if (fin_store) result    <= wdata;
            if (scr_store) scratch_q <= wdata;
        end
    end

    // The finish edge is still a RUN edge, so it is counted by both counters
    sat_counter32 u_cyc_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (run),
        .count (cycle_count)
    );

    sat_counter32 u_stl_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (run && stall_in),
        .count (stall_count)
    );

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_CYC:  rdata = DATA_W'(cycle_count);
            SEL_STL:  rdata = DATA_W'(stall_count);
            SEL_STAT: rdata = DATA_W'(done);
            SEL_SCR:  rdata = scratch_q;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dbus_mmio_resp.sv
// tb/tb_dbus_mmio_resp.sv - self-checking bench for dbus_mmio_resp
module tb_dbus_mmio_resp;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        stall_in;
    logic [31:0] rdata;
    logic        hit;
    logic        done;
    logic [31:0] result;
    logic [31:0] cycle_count;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state
    logic [31:0] m_cyc, m_stl, m_scr, m_res;
    logic        m_done;

    localparam logic [31:0] A_CYC  = 32'h0000_7FF0;
    localparam logic [31:0] A_STL  = 32'h0000_7FF4;
    localparam logic [31:0] A_STAT = 32'h0000_7FF8;
    localparam logic [31:0] A_SCR  = 32'h0000_7FFC;
    localparam logic [31:0] A_FIN  = 32'h0000_7FFF;

    dbus_mmio_resp dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .stall_in    (stall_in),
        .rdata       (rdata),
        .hit         (hit),
        .done        (done),
        .result      (result),
        .cycle_count (cycle_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: model follows the rules of the register map on the rising edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_stl = 0; m_scr = 0; m_res = 0; m_done = 0;
        end else if (!m_done) begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (stall_in && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
            if (we && addr == A_SCR) m_scr = wdata;
            if (we && addr == A_FIN) begin
                m_res  = wdata;
                m_done = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; we = 0; stall_in = 0; wdata = 0; addr = 32'h0000_1000;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    function automatic logic [32:0] model_read(input logic [31:0] a);
        case (a)
            A_CYC:   return {1'b1, m_cyc};
            A_STL:   return {1'b1, m_stl};
            A_STAT:  return {1'b1, 31'd0, m_done};
            A_SCR:   return {1'b1, m_scr};
            A_FIN:   return {1'b1, 32'd0};
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fails++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (cycle_count !== 32'd0) begin n_fails++; $display("FAIL reset_cyc got %0d want 0", cycle_count); end
        n_checks++; if (stall_count !== 32'd0) begin n_fails++; $display("FAIL reset_stl got %0d want 0", stall_count); end
        repeat (10) tick();
        addr = A_CYC; #1;
        n_checks++; if (rdata !== 32'd10 || hit !== 1'b1) begin n_fails++; $display("FAIL idle_cyc_read got %0d hit %0b want 10 hit 1", rdata, hit); end
        addr = A_STL; #1;
        n_checks++; if (rdata !== 32'd0 || hit !== 1'b1) begin n_fails++; $display("FAIL idle_stl_read got %0d hit %0b want 0 hit 1", rdata, hit); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL idle_done got %0b want 0", done); end
    endtask

    task automatic test_stall();
        logic [7:0] pattern;
        pattern = 8'b0101_0010;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            stall_in = pattern[i];
            tick();
        end
        stall_in = 0;
        n_checks++; if (cycle_count !== 32'd8) begin n_fails++; $display("FAIL stall_cyc got %0d want 8", cycle_count); end
        n_checks++; if (stall_count !== 32'd3) begin n_fails++; $display("FAIL stall_stl got %0d want 3", stall_count); end
    endtask

    task automatic test_scratch();
        do_reset();
        addr = A_SCR; wdata = 32'hDEAD_BEEF; we = 1;
        tick();
        we = 0; #1;
        n_checks++; if (rdata !== 32'hDEAD_BEEF || hit !== 1'b1) begin n_fails++; $display("FAIL scratch_read got %h hit %0b want deadbeef hit 1", rdata, hit); end
        addr = A_CYC; wdata = 32'h1234_5678; we = 1;
        tick();
        we = 0;
        n_checks++; if (cycle_count !== 32'd2) begin n_fails++; $display("FAIL ro_write_cyc got %0d want 2", cycle_count); end
        addr = A_STAT; wdata = 32'hFFFF_FFFF; we = 1;
        tick();
        we = 0; #1;
        n_checks++; if (rdata !== 32'd0 || done !== 1'b0) begin n_fails++; $display("FAIL ro_write_stat got %h done %0b want 0 done 0", rdata, done); end
        addr = 32'h0000_8000; #1;
        n_checks++; if (rdata !== 32'd0 || hit !== 1'b0) begin n_fails++; $display("FAIL miss_read got %h hit %0b want 0 hit 0", rdata, hit); end
        addr = A_FIN; #1;
        n_checks++; if (rdata !== 32'd0 || hit !== 1'b1) begin n_fails++; $display("FAIL fin_read got %h hit %0b want 0 hit 1", rdata, hit); end
        addr = 32'h0000_7FFD; #1;
        n_checks++; if (hit !== 1'b0) begin n_fails++; $display("FAIL unaligned_read hit %0b want 0", hit); end
    endtask

    task automatic test_finish();
        do_reset();
        repeat (20) tick();
        addr = A_FIN; wdata = 32'h0000_0037; we = 1; stall_in = 1;
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL finish_early_done got %0b want 0", done); end
        tick();
        we = 0; stall_in = 0;
        n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL finish_done got %0b want 1", done); end
        n_checks++; if (result !== 32'h37) begin n_fails++; $display("FAIL finish_result got %h want 37", result); end
        n_checks++; if (cycle_count !== 32'd21 || stall_count !== 32'd1) begin n_fails++; $display("FAIL finish_counts got %0d/%0d want 21/1", cycle_count, stall_count); end
        for (int i = 0; i < 5; i++) begin
            stall_in = i[0];
            tick();
        end
        stall_in = 0;
        n_checks++; if (cycle_count !== 32'd21 || stall_count !== 32'd1) begin n_fails++; $display("FAIL frozen_counts got %0d/%0d want 21/1", cycle_count, stall_count); end
        addr = A_FIN; wdata = 32'h99; we = 1;
        tick();
        addr = A_SCR; wdata = 32'hCAFE_F00D; we = 1;
        tick();
        we = 0; #1;
        n_checks++; if (result !== 32'h37) begin n_fails++; $display("FAIL second_finish result got %h want 37", result); end
        n_checks++; if (rdata !== 32'd0) begin n_fails++; $display("FAIL done_scratch_write got %h want 0", rdata); end
        addr = A_STAT; #1;
        n_checks++; if (rdata !== 32'd1 || hit !== 1'b1) begin n_fails++; $display("FAIL status_read got %h want 1", rdata); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        repeat (4) tick();
        addr = A_FIN; wdata = 32'h55; we = 1; rst = 1;
        tick();
        rst = 0; we = 0;
        n_checks++; if (done !== 1'b0 || result !== 32'd0) begin n_fails++; $display("FAIL rst_vs_finish done %0b result %h want 0 0", done, result); end
        n_checks++; if (cycle_count !== 32'd0 || stall_count !== 32'd0) begin n_fails++; $display("FAIL rst_vs_finish counts %0d/%0d want 0/0", cycle_count, stall_count); end
        addr = A_FIN; wdata = 32'h66; we = 1;
        tick();
        we = 0;
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if (done !== 1'b0 || result !== 32'd0) begin n_fails++; $display("FAIL rst_in_done done %0b result %h want 0 0", done, result); end
        stall_in = 1;
        repeat (3) tick();
        stall_in = 0;
        n_checks++; if (cycle_count !== 32'd3 || stall_count !== 32'd3) begin n_fails++; $display("FAIL restart_counts %0d/%0d want 3/3", cycle_count, stall_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        force dut.u_cyc_cnt.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_cyc_cnt.count;
        m_cyc = 32'hFFFF_FFFE;
        tick();
        n_checks++; if (cycle_count !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL sat_reach got %h want ffffffff", cycle_count); end
        repeat (2) tick();
        n_checks++; if (cycle_count !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL sat_hold got %h want ffffffff", cycle_count); end
    endtask

    task automatic test_random();
        logic [31:0] addrs [7];
        logic [32:0] exp;
        addrs = '{A_CYC, A_STL, A_STAT, A_SCR, A_FIN, 32'h0000_8000, 32'h0000_7FF1};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            addr     = addrs[$urandom_range(0, 6)];
            wdata    = $urandom;
            we       = ($urandom_range(0, 3) == 0);
            if (addr == A_FIN && $urandom_range(0, 3) != 0) we = 0;
            stall_in = $urandom_range(0, 1);
            #1;
            exp = model_read(addr);
            n_checks++; if ({hit, rdata} !== exp) begin n_fails++; $display("FAIL rand_read[%0d] addr %h got %0b/%h want %0b/%h", i, addr, hit, rdata, exp[32], exp[31:0]); end
            tick();
            n_checks++;
            if (done !== m_done || result !== m_res || cycle_count !== m_cyc || stall_count !== m_stl) begin
                n_fails++;
                $display("FAIL rand_state[%0d] got d%0b r%h c%0d s%0d want d%0b r%h c%0d s%0d", i,
                         done, result, cycle_count, stall_count, m_done, m_res, m_cyc, m_stl);
            end
        end
        idle();
    endtask

    initial begin
        m_cyc = 0; m_stl = 0; m_scr = 0; m_res = 0; m_done = 0;
        idle();
        rst = 1;
        test_reset();
        test_stall();
        test_scratch();
        test_finish();
        test_reset_priority();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
